axil_init_seq: RTL
==================

AXIL_INIT_SEQ -- requirements
Module: axil_init_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 64: command-table entries, power of two.
REQ-002 SHALL have parameter POLL_TIMEOUT, default 1024: maximum POLL read attempts per entry.
REQ-003 SHALL have port axilite_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port axilite_rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_wr_en, input, 1: table write strobe; ignored while busy.
REQ-006 SHALL have port cmd_wr_idx, input, log2(DEPTH): table write index.
REQ-007 SHALL have port cmd_wr_data, input, 66: {op[1:0], addr[31:0], data[31:0]}; op encoding 0=WRITE, 1=POLL, 2=WAIT, 3=END.
REQ-008 SHALL have port start, input, 1: one-cycle pulse that begins execution at entry 0; ignored while busy.
REQ-009 SHALL have port busy, output, 1: sequence executing.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at completion, success or error.
REQ-011 SHALL have port error, output, 1: sticky; cleared by the next accepted start.
REQ-012 SHALL have port err_idx, output, log2(DEPTH): index of the failing entry.
REQ-013 SHALL have port err_code, output, 2: 1=bad BRESP, 2=bad RRESP, 3=POLL timeout or illegal op.
REQ-014 SHALL have ports m_axil_aw*/w*/b*/ar*/r*: AXI4-Lite master, 32-bit address and data; awprot/arprot=0; wstrb=4'hF; upstream of axilite_crossbar_0.

Function
REQ-015 SHALL use FSM states IDLE, FETCH, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, WAIT, DONE.
REQ-016 SHALL, on a start pulse in IDLE, clear error, set idx=0, assert busy the next cycle, and enter FETCH.
REQ-017 SHALL give FETCH a 1-cycle table read, then dispatch on op.
REQ-018 SHALL, for WRITE, assert awvalid and wvalid in the same cycle.
  - Each is held until its own ready is seen.
  - The two may complete in either order or together.
  - Go to WR_RESP when both are accepted.
  - bready=1 only in WR_RESP.
REQ-019 SHALL, for BRESP==OKAY, set idx+1 and go to FETCH; for any other BRESP, set error, err_code=1, and go to DONE.
REQ-020 SHALL, for POLL, issue araddr=addr with rready=1 in RD_DATA.
  - Success when (rdata & data)==data; then set idx+1.
  - If RRESP is not OKAY: err_code=2, go to DONE.
  - Otherwise reissue the read.
  - After POLL_TIMEOUT unsuccessful reads: err_code=3, go to DONE.
REQ-021 SHALL, for WAIT, count data[15:0] cycles in state WAIT, then set idx+1; a count of 0 takes 1 cycle.
REQ-022 SHALL, for END, go to DONE.
REQ-023 SHALL, when idx wraps from DEPTH-1 to 0 without an END, treat that as completion and go to DONE without error.
REQ-024 SHALL, in DONE, pulse done for 1 cycle, deassert busy, and return to IDLE.
REQ-025 SHALL keep valid signals stable and never deassert them before the handshake completes; address and data SHALL be stable while valid.
REQ-026 SHALL have at most one outstanding transaction at any time.
REQ-027 SHALL, when cmd_wr_en and start arrive in the same cycle in IDLE, perform the table write and accept the start; entry 0 as written that cycle SHALL be executed.

Reset
REQ-028 SHALL, on axilite_rst, asynchronously force:
  - state to IDLE;
  - busy, done, error, err_idx, err_code, and all valid/ready outputs to 0;
  - idx and all counters to 0.
REQ-029 SHALL leave table contents unaffected by reset.
REQ-030 SHALL, when reset is asserted mid-transaction, abandon the transaction with no done pulse; a downstream handshake left pending is the integrator's responsibility.

Configuration
REQ-031 SHALL, with AXIL_INIT_SEQ_POLL_EN defined, implement POLL per REQ-020.
REQ-032 SHALL, with AXIL_INIT_SEQ_POLL_EN undefined, omit the poll counter and the read channel logic (arvalid=0, rready=0), and treat op=1 as illegal: error, err_code=3, err_idx=idx, no bus traffic.

Verification
REQ-033 SHALL verify a 3-write sequence: table {WRITE 0x0000_0000 0x10; WRITE 0x0010_0000 0x40; END}, then start -> two AW/W/B handshakes in order; the reg_map slaves read back 0x10 and 0x40; one done pulse; error=0.
REQ-034 SHALL verify DECERR: table {WRITE 0x8000_0000 0x10; WRITE 0x0000_1000 0x20} -> BRESP=2'b11 -> error=1, err_code=1, err_idx=0; the second write is never issued.
REQ-035 SHALL verify POLL success: reg 0x0010_0004 is set to 0x1 after 5 reads; entry {POLL 0x0010_0004 0x1} -> exactly 6 AR handshakes, then continue; error=0.
REQ-036 SHALL verify POLL timeout: POLL_TIMEOUT=8, polled bit never set -> 8 reads, error=1, err_code=3; done pulses once.
REQ-037 SHALL verify backpressure: awready is delayed 3 cycles relative to wready, then the reverse -> awaddr/wdata stable throughout, each accepted exactly once.
REQ-038 SHALL verify reset abort: axilite_rst asserted during WAIT with count 100 -> busy=0 immediately, no done pulse; a subsequent start reruns from entry 0.

Source files
------------

// File: rtl/axil_init_seq.sv
// AXI4-Lite init sequencer: runs a command table of WRITE/POLL/WAIT/END entries.
// Define AXIL_INIT_SEQ_POLL_EN to build the POLL read engine; otherwise op=1 is illegal.
module axil_init_seq #(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned POLL_TIMEOUT = 1024
) (
    input  logic                       axilite_clk,
    input  logic                       axilite_rst,
    input  logic                       cmd_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   cmd_wr_idx,
    input  logic [65:0]                cmd_wr_data,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [$clog2(DEPTH)-1:0]   err_idx,
    output logic [1:0]                 err_code,
    output logic [31:0]                m_axil_awaddr,
    output logic [2:0]                 m_axil_awprot,
    output logic                       m_axil_awvalid,
    input  logic                       m_axil_awready,
    output logic [31:0]                m_axil_wdata,
    output logic [3:0]                 m_axil_wstrb,
    output logic                       m_axil_wvalid,
    input  logic                       m_axil_wready,
    input  logic [1:0]                 m_axil_bresp,
    input  logic                       m_axil_bvalid,
    output logic                       m_axil_bready,
    output logic [31:0]                m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [31:0]                m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [1:0] OpWrite = 2'd0;
    localparam logic [1:0] OpPoll  = 2'd1;
    localparam logic [1:0] OpWait  = 2'd2;
    localparam logic [1:0] OpEnd   = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StFetch, StWrAddrData, StWrResp, StRdAddr, StRdData, StWait, StDone
    } state_e;

    state_e          state_q, state_d;
    logic [65:0]     table_q [DEPTH];
    logic [IW-1:0]   idx_q, idx_d;
    logic [31:0]     cur_addr_q, cur_addr_d;
    logic [31:0]     cur_data_q, cur_data_d;
    logic            aw_done_q, aw_done_d;
    logic            w_done_q, w_done_d;
    logic [15:0]     wait_cnt_q, wait_cnt_d;
    logic            error_q, error_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [IW-1:0]   err_idx_q, err_idx_d;
    logic [65:0]     fetch_entry;
    logic            aw_ok, w_ok, last_entry;

`ifdef AXIL_INIT_SEQ_POLL_EN
    localparam int unsigned PW = $clog2(POLL_TIMEOUT + 1);
    logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
`else
    logic            unused_rd;
    assign unused_rd = ^{m_axil_arready, m_axil_rvalid, m_axil_rresp, m_axil_rdata};
`endif

    // Table is not reset so a loaded sequence survives an abort.
    always_ff @(posedge axilite_clk) begin
        if (cmd_wr_en && !busy) begin
            table_q[cmd_wr_idx] <= cmd_wr_data;
        end
    end

    assign fetch_entry = table_q[idx_q];
    assign last_entry  = (idx_q == IW'(DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_addr_d = cur_addr_q;
        cur_data_d = cur_data_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        wait_cnt_d = wait_cnt_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        aw_ok      = 1'b0;
        w_ok       = 1'b0;
`ifdef AXIL_INIT_SEQ_POLL_EN
        poll_cnt_d = poll_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    error_d    = 1'b0;
                    err_code_d = 2'd0;
                    err_idx_d  = '0;
                    idx_d      = '0;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                cur_addr_d = fetch_entry[63:32];
                cur_data_d = fetch_entry[31:0];
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
                wait_cnt_d = 16'd0;
`ifdef AXIL_INIT_SEQ_POLL_EN
                poll_cnt_d = '0;
`endif
                unique case (fetch_entry[65:64])
                    OpWrite: state_d = StWrAddrData;
                    OpPoll: begin
`ifdef AXIL_INIT_SEQ_POLL_EN
                        state_d = StRdAddr;
`else
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                        err_idx_d  = idx_q;
                        state_d    = StDone;
`endif
                    end
                    OpWait:  state_d = StWait;
                    OpEnd:   state_d = StDone;
                endcase
            end
            StWrAddrData: begin
                // AW and W complete independently; leave once both have been taken.
                aw_ok     = aw_done_q || m_axil_awready;
                w_ok      = w_done_q || m_axil_wready;
                aw_done_d = aw_ok;
                w_done_d  = w_ok;
                if (aw_ok && w_ok) begin
                    state_d = StWrResp;
                end
            end
            StWrResp: begin
                if (m_axil_bvalid) begin
                    if (m_axil_bresp == 2'b00) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = last_entry ? StDone : StFetch;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = 2'd1;
                        err_idx_d  = idx_q;
                        state_d    = StDone;
                    end
                end
            end
            StRdAddr: begin
`ifdef AXIL_INIT_SEQ_POLL_EN
                if (m_axil_arready) begin
                    state_d = StRdData;
                end
`else
                state_d = StIdle;
`endif
            end
            StRdData: begin
`ifdef AXIL_INIT_SEQ_POLL_EN
                if (m_axil_rvalid) begin
                    if (m_axil_rresp != 2'b00) begin
                        error_d    = 1'b1;
                        err_code_d = 2'd2;
                        err_idx_d  = idx_q;
                        state_d    = StDone;
                    end else if ((m_axil_rdata & cur_data_q) == cur_data_q) begin
                        idx_d   = idx_q + IW'(1);
                        state_d = last_entry ? StDone : StFetch;
                    end else if (poll_cnt_q + PW'(1) == PW'(POLL_TIMEOUT)) begin
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                        err_idx_d  = idx_q;
                        state_d    = StDone;
                    end else begin
                        poll_cnt_d = poll_cnt_q + PW'(1);
                        state_d    = StRdAddr;
                    end
                end
`else
                state_d = StIdle;
`endif
            end
            StWait: begin
                // A zero count still spends one cycle here.
                if ({1'b0, wait_cnt_q} + 17'd1 >= {1'b0, cur_data_q[15:0]}) begin
                    idx_d   = idx_q + IW'(1);
                    state_d = last_entry ? StDone : StFetch;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axilite_clk or posedge axilite_rst) begin
        if (axilite_rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            cur_addr_q <= 32'd0;
            cur_data_q <= 32'd0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wait_cnt_q <= 16'd0;
            error_q    <= 1'b0;
            err_code_q <= 2'd0;
            err_idx_q  <= '0;
`ifdef AXIL_INIT_SEQ_POLL_EN
            poll_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_addr_q <= cur_addr_d;
            cur_data_q <= cur_data_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            wait_cnt_q <= wait_cnt_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
`ifdef AXIL_INIT_SEQ_POLL_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    assign busy     = (state_q != StIdle) && (state_q != StDone);
    assign done     = (state_q == StDone);
    assign error    = error_q;
    assign err_code = err_code_q;
    assign err_idx  = err_idx_q;

    assign m_axil_awaddr  = cur_addr_q;
    assign m_axil_awprot  = 3'd0;
    assign m_axil_awvalid = (state_q == StWrAddrData) && !aw_done_q;
    assign m_axil_wdata   = cur_data_q;
    assign m_axil_wstrb   = 4'hF;
    assign m_axil_wvalid  = (state_q == StWrAddrData) && !w_done_q;
    assign m_axil_bready  = (state_q == StWrResp);
    assign m_axil_arprot  = 3'd0;
`ifdef AXIL_INIT_SEQ_POLL_EN
    assign m_axil_araddr  = cur_addr_q;
    assign m_axil_arvalid = (state_q == StRdAddr);
    assign m_axil_rready  = (state_q == StRdData);
`else
    assign m_axil_araddr  = 32'd0;
    assign m_axil_arvalid = 1'b0;
    assign m_axil_rready  = 1'b0;
`endif

endmodule
